// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini-SRC control unit.
//   - ALU operation codes that the sequencer forces on the ALU
//   - instruction opcodes (IR[31:27])
//   - sequencer state encoding and instruction class encoding
//   - ctrl_t: the full strobe bundle produced for one step
//   - op_class(): maps an opcode onto the step program it runs
package cpu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b01011;

    // Three-register ALU instructions occupy the contiguous range OP_ADD..OP_OR.
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // T0..T7 are consecutive so the sequencer can step with +1.
    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU3, CL_IMM, CL_MULDIV, CL_UNARY, CL_LDI, CL_LD, CL_ST, CL_BR,
        CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_e;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       baout;
        logic       pcout;
        logic       mdrout;
        logic       hiout;
        logic       loout;
        logic       zhiout;
        logic       zloout;
        logic       inportout;
        logic       cout;
        logic       pcin;
        logic       incpc;
        logic       marin;
        logic       mdrin;
        logic       irin;
        logic       yin;
        logic       zin;
        logic       hiin;
        logic       loin;
        logic       outportin;
        logic       con_ff_in;
        logic       mdrread;
        logic       wren;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e cls;
        if (op >= OP_ADD && op <= OP_OR) begin
            cls = CL_ALU3;
        end else if (op >= OP_ADDI && op <= OP_ORI) begin
            cls = CL_IMM;
        end else begin
            case (op)
                OP_LD:          cls = CL_LD;
                OP_LDI:         cls = CL_LDI;
                OP_ST:          cls = CL_ST;
                OP_MUL, OP_DIV: cls = CL_MULDIV;
                OP_NEG, OP_NOT: cls = CL_UNARY;
                OP_BR:          cls = CL_BR;
                OP_JR:          cls = CL_JR;
                OP_IN:          cls = CL_IN;
                OP_OUT:         cls = CL_OUT;
                OP_MFHI:        cls = CL_MFHI;
                OP_MFLO:        cls = CL_MFLO;
                OP_HALT:        cls = CL_HALT;
                // jal runs as a nop, like any unlisted opcode
                OP_JAL, OP_NOP: cls = CL_NOP;
                default:        cls = CL_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Combinational step decoder: turns (state, opcode, CON) into the strobe
// bundle for the current step.
// Ports:
//   state     in  current sequencer state
//   opcode    in  IR[31:27]; only consulted from T3 onward
//   con       in  branch condition from the CON flip-flop
//   ctrl      out strobes and ALU opcode for this step
//   last_step out this step ends the instruction
//   halt_op   out this step is T3 of a halt instruction
import cpu_pkg::*;

module cu_step_decode (
    input  state_e     state,
    input  logic [4:0] opcode,
    input  logic       con,
    output ctrl_t      ctrl,
    output logic       last_step,
    output logic       halt_op
);

    op_class_e  cls;
    logic [4:0] imm_alu_op;

    always_comb begin
        cls = op_class(opcode);
        case (opcode)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        halt_op   = 1'b0;

        // While an instruction runs the ALU defaults to add; idle states drive 0.
        if (state != ST_RESET && state != ST_HALT) begin
            ctrl.alu_op = ALU_ADD;
        end

        // Fetch is the same for every instruction; IR is not yet valid here.
        case (state)
            ST_T0: begin ctrl.pcout  = 1'b1; ctrl.marin = 1'b1; ctrl.incpc = 1'b1; end
            ST_T1: begin ctrl.mdrread = 1'b1; ctrl.mdrin = 1'b1; end
            ST_T2: begin ctrl.mdrout = 1'b1; ctrl.irin = 1'b1; end
            default: ;
        endcase

        case (cls)
            CL_ALU3, CL_IMM: begin
                case (state)
                    ST_T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                    ST_T4: begin
                        ctrl.zin = 1'b1;
                        if (cls == CL_IMM) begin
                            ctrl.cout   = 1'b1;
                            ctrl.alu_op = imm_alu_op;
                        end else begin
                            ctrl.grc    = 1'b1;
                            ctrl.rout   = 1'b1;
                            ctrl.alu_op = opcode;
                        end
                    end
                    ST_T5: begin ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last_step = 1'b1; end
                    default: ;
                endcase
            end
            CL_MULDIV: begin
                case (state)
                    ST_T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                    ST_T4: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode; end
                    ST_T5: begin ctrl.zloout = 1'b1; ctrl.loin = 1'b1; end
                    ST_T6: begin ctrl.zhiout = 1'b1; ctrl.hiin = 1'b1; last_step = 1'b1; end
                    default: ;
                endcase
            end
            CL_UNARY: begin
                case (state)
                    ST_T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_op = opcode; end
                    ST_T4: begin ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; last_step = 1'b1; end
                    default: ;
                endcase
            end
            // ldi, ld and st share the effective-address computation in T3/T4.
            CL_LDI, CL_LD, CL_ST: begin
                case (state)
                    ST_T3: begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1; end
                    ST_T4: begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; end
                    ST_T5: begin
                        ctrl.zloout = 1'b1;
                        if (cls == CL_LDI) begin
                            ctrl.gra  = 1'b1;
                            ctrl.rin  = 1'b1;
                            last_step = 1'b1;
                        end else begin
                            ctrl.marin = 1'b1;
                        end
                    end
                    ST_T6: begin
                        ctrl.mdrin = 1'b1;
                        if (cls == CL_LD) begin
                            ctrl.mdrread = 1'b1;
                        end else begin
                            // st: MDR loads the source register from the bus
                            ctrl.gra  = 1'b1;
                            ctrl.rout = 1'b1;
                        end
                    end
                    ST_T7: begin
                        last_step = 1'b1;
                        if (cls == CL_LD) begin
                            ctrl.mdrout = 1'b1;
                            ctrl.gra    = 1'b1;
                            ctrl.rin    = 1'b1;
                        end else begin
                            ctrl.wren = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            CL_BR: begin
                case (state)
                    ST_T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_ff_in = 1'b1; end
                    ST_T4: begin ctrl.pcout = 1'b1; ctrl.yin = 1'b1; end
                    ST_T5: begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; end
                    ST_T6: begin
                        last_step = 1'b1;
                        if (con) begin
                            ctrl.zloout = 1'b1;
                            ctrl.pcin   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                // All remaining classes finish in T3.
                if (state == ST_T3) begin
                    last_step = 1'b1;
                    case (cls)
                        CL_JR:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1; end
                        CL_IN:   begin ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                        CL_OUT:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outportin = 1'b1; end
                        CL_MFHI: begin ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                        CL_MFLO: begin ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                        CL_HALT: halt_op = 1'b1;
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC hardwired control unit. Sequences every instruction through
// T0..T7 (one clock per step) and drives all datapath control strobes.
// Ports:
//   clk, clr         clock (rising edge) and synchronous active-high reset
//   IR               instruction register; opcode is IR[31:27]
//   CON              branch condition flip-flop
//   Stop             request to halt once the current instruction completes
//   Run              high while an instruction is executing
//   Gra..BAout       register select/encode controls
//   PCout..Cout      bus-source enables (at most one per step)
//   PCin..CON_ff_in  register load enables
//   MDRread, WRen    MDR source select and memory write strobe
//   ZLowSelect/ZHighSelect  copies of ZLOout/ZHIout
//   ALU_opcode       ALU operation
import cpu_pkg::*;

module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        MDRout,
    output logic        HIout,
    output logic        Loout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        Loin,
    output logic        OutPortin,
    output logic        CON_ff_in,
    output logic        MDRread,
    output logic        WRen,
    output logic        ZLowSelect,
    output logic        ZHighSelect,
    output logic [4:0]  ALU_opcode
);

    state_e state_q, state_d;
    logic   stop_pending_q, stop_pending_d;
    ctrl_t  dec_ctrl, ctrl;
    logic   dec_last, dec_halt;
    logic   ir_unused;

    // Only the opcode field steers sequencing.
    assign ir_unused = ^IR[26:0];

    cu_step_decode u_decode (
        .state     (state_q),
        .opcode    (IR[31:27]),
        .con       (CON),
        .ctrl      (dec_ctrl),
        .last_step (dec_last),
        .halt_op   (dec_halt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= ST_RESET;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Next state. A Stop seen in the final step still counts for that
    // instruction, hence stop_pending_d rather than stop_pending_q.
    always_comb begin
        stop_pending_d = stop_pending_q | Stop;
        state_d        = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default: begin
                if (dec_halt || (dec_last && stop_pending_d)) begin
                    state_d = ST_HALT;
                end else if (dec_last) begin
                    state_d = ST_T0;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        endcase
    end

    // Outputs: clr blanks everything in the cycle it is asserted, so an
    // abandoned instruction can never write a register or memory.
    always_comb begin
        ctrl = clr ? '0 : dec_ctrl;
        Run  = !clr && (state_q != ST_RESET) && (state_q != ST_HALT);
    end

    assign Gra         = ctrl.gra;
    assign Grb         = ctrl.grb;
    assign Grc         = ctrl.grc;
    assign Rin         = ctrl.rin;
    assign Rout        = ctrl.rout;
    assign BAout       = ctrl.baout;
    assign PCout       = ctrl.pcout;
    assign MDRout      = ctrl.mdrout;
    assign HIout       = ctrl.hiout;
    assign Loout       = ctrl.loout;
    assign ZHIout      = ctrl.zhiout;
    assign ZLOout      = ctrl.zloout;
    assign InPortout   = ctrl.inportout;
    assign Cout        = ctrl.cout;
    assign PCin        = ctrl.pcin;
    assign IncPC       = ctrl.incpc;
    assign MARin       = ctrl.marin;
    assign MDRin       = ctrl.mdrin;
    assign IRin        = ctrl.irin;
    assign Yin         = ctrl.yin;
    assign Zin         = ctrl.zin;
    assign HIin        = ctrl.hiin;
    assign Loin        = ctrl.loin;
    assign OutPortin   = ctrl.outportin;
    assign CON_ff_in   = ctrl.con_ff_in;
    assign MDRread     = ctrl.mdrread;
    assign WRen        = ctrl.wren;
    assign ZLowSelect  = ctrl.zloout;
    assign ZHighSelect = ctrl.zhiout;
    assign ALU_opcode  = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a random
// instruction stream, checked against a step-table model of each instruction.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR = '0;
    logic        CON = 1'b0;
    logic        Stop = 1'b0;
    logic Run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, MDRout, HIout, Loout;
    logic ZHIout, ZLOout, InPortout, Cout, PCin, IncPC, MARin, MDRin, IRin;
    logic Yin, Zin, HIin, Loin, OutPortin, CON_ff_in, MDRread, WRen;
    logic ZLowSelect, ZHighSelect;
    logic [4:0] ALU_opcode;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .Loout(Loout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .Loin(Loin), .OutPortin(OutPortin),
        .CON_ff_in(CON_ff_in), .MDRread(MDRread), .WRen(WRen),
        .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .ALU_opcode(ALU_opcode)
    );

    always #5 clk = ~clk;

    logic [26:0] obs;
    assign obs = {WRen, MDRread, CON_ff_in, OutPortin, Loin, HIin, Zin, Yin, IRin,
                  MDRin, MARin, IncPC, PCin, Cout, InPortout, ZLOout, ZHIout, Loout,
                  HIout, MDRout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

    localparam logic [26:0] M_GRA = 27'd1 << 0,  M_GRB = 27'd1 << 1,  M_GRC = 27'd1 << 2;
    localparam logic [26:0] M_RIN = 27'd1 << 3,  M_ROUT = 27'd1 << 4, M_BAOUT = 27'd1 << 5;
    localparam logic [26:0] M_PCOUT = 27'd1 << 6, M_MDROUT = 27'd1 << 7, M_HIOUT = 27'd1 << 8;
    localparam logic [26:0] M_LOOUT = 27'd1 << 9, M_ZHIOUT = 27'd1 << 10, M_ZLOOUT = 27'd1 << 11;
    localparam logic [26:0] M_INPORT = 27'd1 << 12, M_COUT = 27'd1 << 13, M_PCIN = 27'd1 << 14;
    localparam logic [26:0] M_INCPC = 27'd1 << 15, M_MARIN = 27'd1 << 16, M_MDRIN = 27'd1 << 17;
    localparam logic [26:0] M_IRIN = 27'd1 << 18, M_YIN = 27'd1 << 19, M_ZIN = 27'd1 << 20;
    localparam logic [26:0] M_HIIN = 27'd1 << 21, M_LOIN = 27'd1 << 22, M_OUTPORT = 27'd1 << 23;
    localparam logic [26:0] M_CONFF = 27'd1 << 24, M_MDRREAD = 27'd1 << 25, M_WREN = 27'd1 << 26;

    // ---------------- reference model ----------------
    function automatic int n_steps(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd14) return 6;
        if (op == 5'd1) return 6;
        if (op == 5'd0 || op == 5'd2) return 8;
        if (op == 5'd15 || op == 5'd16 || op == 5'd19) return 7;
        if (op == 5'd17 || op == 5'd18) return 5;
        return 4;
    endfunction

    function automatic logic [26:0] exp_vec(input int s, input logic [4:0] op, input logic con);
        logic [26:0] v;
        v = '0;
        case (s)
            0: v = M_PCOUT | M_MARIN | M_INCPC;
            1: v = M_MDRREAD | M_MDRIN;
            2: v = M_MDROUT | M_IRIN;
            default: begin
                if (op >= 5'd3 && op <= 5'd14) begin
                    if (s == 3) v = M_GRB | M_ROUT | M_YIN;
                    if (s == 4) v = (op <= 5'd11) ? (M_GRC | M_ROUT | M_ZIN) : (M_COUT | M_ZIN);
                    if (s == 5) v = M_ZLOOUT | M_GRA | M_RIN;
                end else if (op == 5'd15 || op == 5'd16) begin
                    if (s == 3) v = M_GRA | M_ROUT | M_YIN;
                    if (s == 4) v = M_GRB | M_ROUT | M_ZIN;
                    if (s == 5) v = M_ZLOOUT | M_LOIN;
                    if (s == 6) v = M_ZHIOUT | M_HIIN;
                end else if (op == 5'd17 || op == 5'd18) begin
                    if (s == 3) v = M_GRB | M_ROUT | M_ZIN;
                    if (s == 4) v = M_ZLOOUT | M_GRA | M_RIN;
                end else if (op <= 5'd2) begin
                    if (s == 3) v = M_GRB | M_BAOUT | M_YIN;
                    if (s == 4) v = M_COUT | M_ZIN;
                    if (s == 5) v = (op == 5'd1) ? (M_ZLOOUT | M_GRA | M_RIN) : (M_ZLOOUT | M_MARIN);
                    if (s == 6) v = (op == 5'd0) ? (M_MDRREAD | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
                    if (s == 7) v = (op == 5'd0) ? (M_MDROUT | M_GRA | M_RIN) : M_WREN;
                end else if (op == 5'd19) begin
                    if (s == 3) v = M_GRA | M_ROUT | M_CONFF;
                    if (s == 4) v = M_PCOUT | M_YIN;
                    if (s == 5) v = M_COUT | M_ZIN;
                    if (s == 6) v = con ? (M_ZLOOUT | M_PCIN) : '0;
                end else if (s == 3) begin
                    case (op)
                        5'd20: v = M_GRA | M_ROUT | M_PCIN;
                        5'd22: v = M_INPORT | M_GRA | M_RIN;
                        5'd23: v = M_GRA | M_ROUT | M_OUTPORT;
                        5'd24: v = M_HIOUT | M_GRA | M_RIN;
                        5'd25: v = M_LOOUT | M_GRA | M_RIN;
                        default: v = '0;
                    endcase
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic [4:0] exp_alu(input int s, input logic [4:0] op);
        if (s == 4 && op >= 5'd3 && op <= 5'd11) return op;
        if (s == 4 && op == 5'd13) return 5'b01010;
        if (s == 4 && op == 5'd14) return 5'b01011;
        if (s == 4 && (op == 5'd15 || op == 5'd16)) return op;
        if (s == 3 && (op == 5'd17 || op == 5'd18)) return op;
        return 5'b00011;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in RESET with clr low; the next adv() enters T0.
    task automatic do_reset();
        Stop = 1'b0;
        clr  = 1'b1;
        adv();
        adv();
        clr  = 1'b0;
    endtask

    // ---------------- continuous bus-source check ----------------
    always @(negedge clk) begin
        checks++;
        if ($countones({PCout, MDRout, HIout, Loout, ZHIout, ZLOout, InPortout, Cout}) > 1 ||
            ZLowSelect !== ZLOout || ZHighSelect !== ZHIout) begin
            errors++;
            $display("FAIL bus_sources: srcs=%b zsel=%b%b, want at most one src and zsel=%b%b",
                     {PCout, MDRout, HIout, Loout, ZHIout, ZLOout, InPortout, Cout},
                     ZLowSelect, ZHighSelect, ZLOout, ZHIout);
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [4:0] op;
        op   = 5'd26;
        clr  = 1'b1;
        Stop = 1'b1;
        adv();
        @(negedge clk);
        checks++;
        if (obs !== '0 || Run !== 1'b0 || ALU_opcode !== 5'd0) begin
            errors++;
            $display("FAIL reset_clr: strobes=%h run=%b alu=%h, want 0/0/0", obs, Run, ALU_opcode);
        end
        adv();
        clr  = 1'b0;
        Stop = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0 || Run !== 1'b0 || ALU_opcode !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: strobes=%h run=%b alu=%h, want 0/0/0", obs, Run, ALU_opcode);
        end
        adv();
        // Stop held during clr must not halt: a nop runs and T0 follows.
        for (int s = 0; s < 5; s++) begin
            IR = (s < 3) ? $urandom : {op, 27'h0};
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(s % 4, op, CON) || Run !== 1'b1 || ALU_opcode !== 5'b00011) begin
                errors++;
                $display("FAIL reset_seq s%0d: strobes=%h run=%b alu=%h, want strobes=%h run=1 alu=03",
                         s, obs, Run, ALU_opcode, exp_vec(s % 4, op, CON));
            end
            adv();
        end
    endtask

    task automatic test_add();
        logic [31:0] instr;
        logic [4:0]  op;
        instr = 32'h19888000;
        op    = instr[31:27];
        do_reset();
        adv();
        for (int s = 0; s < 7; s++) begin
            IR = (s < 3) ? $urandom : instr;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(s % 6, op, CON) || ALU_opcode !== exp_alu(s % 6, op) || Run !== 1'b1) begin
                errors++;
                $display("FAIL add s%0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                         s, obs, ALU_opcode, Run, exp_vec(s % 6, op, CON), exp_alu(s % 6, op));
            end
            adv();
        end
    endtask

    task automatic test_st();
        logic [31:0] instr;
        logic [4:0]  op;
        int          wren_cnt;
        instr    = 32'h10800064;
        op       = instr[31:27];
        wren_cnt = 0;
        do_reset();
        adv();
        for (int s = 0; s < 9; s++) begin
            IR = (s < 3) ? $urandom : instr;
            @(negedge clk);
            if (WRen === 1'b1) wren_cnt++;
            checks++;
            if (obs !== exp_vec(s % 8, op, CON) || ALU_opcode !== exp_alu(s % 8, op) || Run !== 1'b1) begin
                errors++;
                $display("FAIL st s%0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                         s, obs, ALU_opcode, Run, exp_vec(s % 8, op, CON), exp_alu(s % 8, op));
            end
            adv();
        end
        checks++;
        if (wren_cnt != 1) begin
            errors++;
            $display("FAIL st_wren_count: got %0d, want 1", wren_cnt);
        end
    endtask

    task automatic test_br();
        logic [31:0] instr;
        logic [4:0]  op;
        op = 5'd19;
        for (int c = 1; c >= 0; c--) begin
            instr = {op, 27'($urandom)};
            CON   = c[0];
            do_reset();
            adv();
            for (int s = 0; s < 8; s++) begin
                IR = (s < 3) ? $urandom : instr;
                @(negedge clk);
                checks++;
                if (obs !== exp_vec(s % 7, op, CON) || ALU_opcode !== exp_alu(s % 7, op) || Run !== 1'b1) begin
                    errors++;
                    $display("FAIL br con=%0d s%0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                             c, s, obs, ALU_opcode, Run, exp_vec(s % 7, op, CON), exp_alu(s % 7, op));
                end
                adv();
            end
        end
        CON = 1'b0;
    endtask

    task automatic test_stop_mul();
        logic [31:0] instr;
        logic [4:0]  op;
        op    = 5'd15;
        instr = {op, 27'($urandom)};
        do_reset();
        adv();
        for (int s = 0; s < 7; s++) begin
            IR   = (s < 3) ? $urandom : instr;
            Stop = (s == 4);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(s, op, CON) || ALU_opcode !== exp_alu(s, op) || Run !== 1'b1) begin
                errors++;
                $display("FAIL mul_stop s%0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                         s, obs, ALU_opcode, Run, exp_vec(s, op, CON), exp_alu(s, op));
            end
            adv();
        end
        Stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            IR = $urandom;
            @(negedge clk);
            checks++;
            if (obs !== '0 || Run !== 1'b0 || ALU_opcode !== 5'd0) begin
                errors++;
                $display("FAIL mul_halt c%0d: strobes=%h run=%b alu=%h, want 0/0/0", k, obs, Run, ALU_opcode);
            end
            adv();
        end
        do_reset();
        adv();
        @(negedge clk);
        checks++;
        if (obs !== exp_vec(0, op, CON) || Run !== 1'b1) begin
            errors++;
            $display("FAIL halt_restart: strobes=%h run=%b, want strobes=%h run=1", obs, Run, exp_vec(0, op, CON));
        end
    endtask

    task automatic test_clr_mid_st();
        logic [31:0] instr;
        logic [4:0]  op;
        op    = 5'd2;
        instr = {op, 27'($urandom)};
        do_reset();
        adv();
        for (int s = 0; s < 6; s++) begin
            IR = (s < 3) ? $urandom : instr;
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(s, op, CON) || Run !== 1'b1) begin
                errors++;
                $display("FAIL clr_st s%0d: strobes=%h run=%b, want strobes=%h run=1", s, obs, Run, exp_vec(s, op, CON));
            end
            adv();
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0 || Run !== 1'b0 || ALU_opcode !== 5'd0) begin
            errors++;
            $display("FAIL clr_in_t6: strobes=%h run=%b alu=%h, want 0/0/0", obs, Run, ALU_opcode);
        end
        adv();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== ((k == 0) ? 27'd0 : exp_vec(0, op, CON)) || Run !== k[0]) begin
                errors++;
                $display("FAIL clr_after c%0d: strobes=%h run=%b, want strobes=%h run=%0d",
                         k, obs, Run, (k == 0) ? 27'd0 : exp_vec(0, op, CON), k);
            end
            adv();
        end
    endtask

    task automatic test_halt_op();
        logic [4:0] op;
        op = 5'd27;
        do_reset();
        adv();
        for (int s = 0; s < 7; s++) begin
            IR   = (s < 3) ? $urandom : {op, 27'($urandom)};
            Stop = 1'b0;
            @(negedge clk);
            checks++;
            if (s < 4 && (obs !== exp_vec(s, op, CON) || Run !== 1'b1)) begin
                errors++;
                $display("FAIL halt_op s%0d: strobes=%h run=%b, want strobes=%h run=1", s, obs, Run, exp_vec(s, op, CON));
            end else if (s >= 4 && (obs !== '0 || Run !== 1'b0)) begin
                errors++;
                $display("FAIL halt_op_idle s%0d: strobes=%h run=%b, want 0/0", s, obs, Run);
            end
            adv();
        end
    endtask

    task automatic test_random();
        logic [31:0] instr;
        logic [4:0]  op;
        logic        pend;
        int          n;
        do_reset();
        adv();
        for (int k = 0; k < 60; k++) begin
            op    = 5'($urandom_range(0, 31));
            instr = {op, 27'($urandom)};
            n     = n_steps(op);
            pend  = 1'b0;
            for (int s = 0; s < n; s++) begin
                IR   = (s < 3) ? $urandom : instr;
                CON  = 1'($urandom);
                Stop = ($urandom_range(0, 39) == 0);
                pend = pend | Stop;
                @(negedge clk);
                checks++;
                if (obs !== exp_vec(s, op, CON) || ALU_opcode !== exp_alu(s, op) || Run !== 1'b1) begin
                    errors++;
                    $display("FAIL rand i%0d op=%h s%0d: strobes=%h alu=%h run=%b, want strobes=%h alu=%h run=1",
                             k, op, s, obs, ALU_opcode, Run, exp_vec(s, op, CON), exp_alu(s, op));
                end
                adv();
            end
            Stop = 1'b0;
            if (pend || op == 5'd27) begin
                @(negedge clk);
                checks++;
                if (obs !== '0 || Run !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_halt i%0d: strobes=%h run=%b, want 0/0", k, obs, Run);
                end
                do_reset();
                adv();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_st();
        test_br();
        test_stop_mul();
        test_clr_mid_st();
        test_halt_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
